sink_table_agent: RTL and testbench
===================================

# sink_table_agent

Request-driven initiator for the node's shared 16-bit data memory port: given a sink ID, it scans the knownSinks list (word entries from 0x008) bounded by knownSinkCount (0x688). It reports whether and where the ID is present and, on request, appends a missing ID and increments the count. It sits between the routing control FSMs and the memory, and is the sole driver of the memory's address, write-enable and write-data inputs while a request is in flight.

## Interface
- SINK_BASE, 11'h008, byte address of knownSinks entry 0
- COUNT_ADDR, 11'h688, byte address of knownSinkCount word
- MAX_SINKS, 16, list capacity in entries
- clock  in  1  rising-edge clock
- nrst  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  high only in IDLE
- req_id  in  16  sink ID to find
- req_insert  in  1  append req_id if absent
- resp_valid  out  1  one-cycle response strobe
- resp_found  out  1  ID already present
- resp_inserted  out  1  ID was appended by this request
- resp_full  out  1  absent, insert requested, list full
- resp_index  out  5  entry index of match or of new entry
- mem_address  out  11  byte address to memory
- mem_wr_en  out  1  memory write enable
- mem_wdata  out  16  word to memory (high byte at mem_address, low byte at +1)
- mem_rdata  in  16  word from memory, combinational from mem_address

## Operation
- Memory words are big-endian byte pairs: entry i lives at SINK_BASE + 2*i. Reads are combinational and are sampled in the same cycle the address is driven. Writes commit on the rising edge while mem_wr_en=1.
- FSM states and transitions:
  - IDLE: req_ready=1. When req_valid=1, latch req_id/req_insert, clear idx and go to RDCNT.
  - RDCNT: address COUNT_ADDR. Latch cnt = min(mem_rdata, MAX_SINKS) (5-bit), then go to SCAN.
  - SCAN: if idx==cnt, go to WRENT when insert=1 and cnt<MAX_SINKS, else go to DONE with found=0 (full=1 if insert=1 and cnt==MAX_SINKS). If idx<cnt, address SINK_BASE+2*idx. On mem_rdata==id go to DONE with found=1 and index=idx; otherwise idx++.
  - WRENT: address SINK_BASE+2*cnt, mem_wr_en=1, mem_wdata=id, then go to WRCNT.
  - WRCNT: address COUNT_ADDR, mem_wr_en=1, mem_wdata=cnt+1 zero-extended. Go to DONE with inserted=1, index=cnt.
  - DONE: resp_valid=1 for one cycle, then return to IDLE.
- resp_found/inserted/full/index are registered and hold their values until the next DONE. At most one of found, inserted and full is 1.
- A first match wins; duplicates beyond it are never examined. ID 0 is an ordinary ID.
- mem_address=0, mem_wr_en=0 and mem_wdata=0 in IDLE, RDCNT-excluded states without access, and DONE. mem_wr_en is 1 only in WRENT/WRCNT.
- req_valid is ignored outside IDLE. A requester holding req_valid high through DONE starts a new request on the IDLE cycle.

## Timing
- Reset (nrst=0, asynchronous) puts the FSM in IDLE. All resp_* outputs, mem_wr_en, mem_address, mem_wdata and idx are 0. req_ready is 1 after reset release.
- Request accepted at edge E0; RDCNT occupies cycle 1.
- Match at index i: SCAN occupies cycles 2..i+2, and resp_valid is high in cycle i+3.
- Miss without insert, or full: resp_valid is high in cycle cnt+3.
- Insert: the entry write commits at the end of cycle cnt+3 and the count write at the end of cycle cnt+4. resp_valid is high in cycle cnt+5.
- Empty list (cnt=0): a miss responds in cycle 3, an insert in cycle 5.
- Reset between WRENT and WRCNT leaves the entry written but the count unchanged. The stale word lies beyond the count and is never read.
- Stored count >MAX_SINKS is clamped and the memory is never accessed past entry MAX_SINKS-1.

## Test plan
- Preload entries {2,5,10,171,205}, count=5. Request id=10, insert=0 -> resp_valid in cycle 5, found=1, index=2, no memory writes.
- Same preload. Request id=7, insert=1 -> word 7 written at 0x012, count word 0x688 becomes 6, resp_valid in cycle 10 with inserted=1, index=5. A follow-up request for id=7 -> found=1, index=5.
- Same preload. Request id=7, insert=0 -> resp_valid in cycle 8, all flags 0, memory unchanged.
- Count=16 with distinct IDs 1..16. Request id=99, insert=1 -> full=1, no write, resp_valid in cycle 19. Count=40 with 16 entries -> same result and no address above 0x026.
- Count=0. Request id=0, insert=1 -> entry 0 written 0, count becomes 1, index=0, resp_valid in cycle 5.
- Drop nrst in WRCNT -> outputs zero at once, count word unchanged, req_ready=1 after release. Back-to-back requests with req_valid held high -> each is accepted exactly once per IDLE cycle.

Source files
------------

// File: rtl/sink_table_agent_if.sv
// Bundle between the sink table agent, its requester and the shared data memory port.
//   req_*  : request handshake (requester -> agent, req_ready back)
//   resp_* : one-cycle response strobe plus held result flags (agent -> requester)
//   mem_*  : 16-bit big-endian word port; mem_rdata is combinational from mem_address
// The slave modport is the agent's view. The master modport is the combined
// requester + memory view that drives requests and returns read data.
interface sink_table_agent_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_id;
  logic        req_insert;
  logic        resp_valid;
  logic        resp_found;
  logic        resp_inserted;
  logic        resp_full;
  logic [4:0]  resp_index;
  logic [10:0] mem_address;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport master (
    output req_valid, req_id, req_insert, mem_rdata,
    input  req_ready, resp_valid, resp_found, resp_inserted, resp_full, resp_index,
    input  mem_address, mem_wr_en, mem_wdata
  );

  modport slave (
    input  req_valid, req_id, req_insert, mem_rdata,
    output req_ready, resp_valid, resp_found, resp_inserted, resp_full, resp_index,
    output mem_address, mem_wr_en, mem_wdata
  );
endinterface

// File: rtl/sink_table_agent.sv
// Sink table agent: looks up a sink ID in the knownSinks list held in data memory
// (word entries from SINK_BASE, length in the knownSinkCount word at COUNT_ADDR),
// reports whether and where it is present and optionally appends it.
// Ports:
//   clock : rising-edge clock
//   nrst  : asynchronous active-low reset
//   bus   : slave view of sink_table_agent_if (request, response and memory port)
module sink_table_agent (
  input logic               clock,
  input logic               nrst,
  sink_table_agent_if.slave bus
);

  localparam logic [10:0] SINK_BASE  = 11'h008;
  localparam logic [10:0] COUNT_ADDR = 11'h688;
  localparam logic [4:0]  MAX_SINKS  = 5'd16;

  typedef enum logic [2:0] {
    StIdle,
    StRdCnt,
    StScan,
    StWrEnt,
    StWrCnt,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] id_q;
  logic        insert_q;
  logic [4:0]  idx_q;
  logic [4:0]  cnt_q;
  logic        found_q, inserted_q, full_q;
  logic [4:0]  index_q;

  logic        scan_end;
  logic        scan_hit;
  logic        can_insert;
  logic [4:0]  cnt_clamped;

  assign scan_end    = (idx_q == cnt_q);
  assign scan_hit    = !scan_end && (bus.mem_rdata == id_q);
  assign can_insert  = insert_q && (cnt_q < MAX_SINKS);
  // Oversized stored counts are clamped so the scan never leaves the table.
  assign cnt_clamped = (bus.mem_rdata > 16'(MAX_SINKS)) ? MAX_SINKS : bus.mem_rdata[4:0];

  // State register.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.req_valid) state_d = StRdCnt;
      StRdCnt: state_d = StScan;
      StScan: begin
        if (scan_end) begin
          state_d = can_insert ? StWrEnt : StDone;
        end else if (scan_hit) begin
          state_d = StDone;
        end
      end
      StWrEnt: state_d = StWrCnt;
      StWrCnt: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request context, scan pointer and held response flags.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      id_q       <= '0;
      insert_q   <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      found_q    <= 1'b0;
      inserted_q <= 1'b0;
      full_q     <= 1'b0;
      index_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            id_q     <= bus.req_id;
            insert_q <= bus.req_insert;
            idx_q    <= '0;
          end
        end
        StRdCnt: cnt_q <= cnt_clamped;
        StScan: begin
          if (scan_end) begin
            // Miss: respond now unless an append is still possible.
            if (!can_insert) begin
              found_q    <= 1'b0;
              inserted_q <= 1'b0;
              full_q     <= insert_q;
              index_q    <= '0;
            end
          end else if (scan_hit) begin
            found_q    <= 1'b1;
            inserted_q <= 1'b0;
            full_q     <= 1'b0;
            index_q    <= idx_q;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        StWrCnt: begin
          found_q    <= 1'b0;
          inserted_q <= 1'b1;
          full_q     <= 1'b0;
          index_q    <= cnt_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs: memory port is idle (all zero) except while an access is in flight.
  always_comb begin
    bus.mem_address = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wdata   = '0;
    case (state_q)
      StRdCnt: bus.mem_address = COUNT_ADDR;
      StScan: begin
        if (!scan_end) bus.mem_address = SINK_BASE + {5'd0, idx_q, 1'b0};
      end
      StWrEnt: begin
        bus.mem_address = SINK_BASE + {5'd0, cnt_q, 1'b0};
        bus.mem_wr_en   = 1'b1;
        bus.mem_wdata   = id_q;
      end
      StWrCnt: begin
        bus.mem_address = COUNT_ADDR;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wdata   = {11'd0, cnt_q + 5'd1};
      end
      default: ;
    endcase
  end

  assign bus.req_ready     = (state_q == StIdle);
  assign bus.resp_valid    = (state_q == StDone);
  assign bus.resp_found    = found_q;
  assign bus.resp_inserted = inserted_q;
  assign bus.resp_full     = full_q;
  assign bus.resp_index    = index_q;

endmodule

// File: tb/tb_sink_table_agent.sv
// Testbench for sink_table_agent: byte-wide memory model, list-level reference
// model feeding a scoreboard queue, and a monitor that checks each response.
module tb_sink_table_agent;

  localparam logic [10:0] SINK_BASE  = 11'h008;
  localparam logic [10:0] COUNT_ADDR = 11'h688;

  logic clock = 1'b0;
  logic nrst  = 1'b1;
  always #5 clock = ~clock;

  sink_table_agent_if bus ();

  sink_table_agent dut (
    .clock (clock),
    .nrst  (nrst),
    .bus   (bus)
  );

  // Memory: big-endian byte pairs, combinational read.
  logic [7:0]  mem [2048];
  logic        pl_en   = 1'b0;
  logic [10:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  assign bus.mem_rdata = {mem[bus.mem_address], mem[bus.mem_address + 11'd1]};

  always @(posedge clock) begin
    if (pl_en) begin
      mem[pl_addr]         <= pl_data[15:8];
      mem[pl_addr + 11'd1] <= pl_data[7:0];
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_address]         <= bus.mem_wdata[15:8];
      mem[bus.mem_address + 11'd1] <= bus.mem_wdata[7:0];
    end
  end

  function automatic logic [15:0] word(input logic [10:0] a);
    logic [10:0] b;
    b = a + 11'd1;
    return {mem[a], mem[b]};
  endfunction

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: the list as plain words plus the raw count word.
  typedef struct {
    logic       found;
    logic       inserted;
    logic       full;
    logic       idx_chk;
    logic [4:0] index;
    int         acc;
    int         lat;
    int         writes;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_entries [16];
  int          ref_count;

  function automatic exp_t model_req(input logic [15:0] id, input logic ins);
    exp_t e;
    int   n;
    n = (ref_count > 16) ? 16 : ref_count;
    e.found = 0; e.inserted = 0; e.full = 0; e.idx_chk = 0; e.index = '0;
    e.acc = cyc; e.lat = n + 3; e.writes = 0;
    for (int i = 0; i < n; i++) begin
      if (ref_entries[i] == id) begin
        e.found = 1; e.index = 5'(i); e.idx_chk = 1; e.lat = i + 3;
        return e;
      end
    end
    if (ins && n < 16) begin
      ref_entries[n] = id;
      ref_count      = n + 1;
      e.inserted = 1; e.index = 5'(n); e.idx_chk = 1; e.lat = n + 5; e.writes = 2;
    end else if (ins) begin
      e.full = 1;
    end
    return e;
  endfunction

  // Monitor: pops one expectation per response strobe.
  int         wr_cnt   = 0;
  int         bad_addr = 0;
  logic       last_found, last_inserted, last_full;
  logic [4:0] last_index;
  int         last_lat;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (!nrst) begin
        wr_cnt = 0;
        bad_addr = 0;
      end else begin
        if (bus.mem_wr_en) wr_cnt++;
        if (!(bus.mem_address == 11'd0 || bus.mem_address == COUNT_ADDR ||
              (bus.mem_address >= SINK_BASE && bus.mem_address <= 11'h026 &&
               !bus.mem_address[0])))
          bad_addr++;
        if (bus.resp_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("resp_found", bus.resp_found, e.found);
            check("resp_inserted", bus.resp_inserted, e.inserted);
            check("resp_full", bus.resp_full, e.full);
            if (e.idx_chk) check("resp_index", bus.resp_index, e.index);
            check("resp_latency", cyc - e.acc, e.lat);
            check("mem_writes", wr_cnt, e.writes);
            check("addr_range", bad_addr, 0);
            last_found    = bus.resp_found;
            last_inserted = bus.resp_inserted;
            last_full     = bus.resp_full;
            last_index    = bus.resp_index;
            last_lat      = cyc - e.acc;
          end
          wr_cnt = 0;
          bad_addr = 0;
        end
      end
    end
  end

  // All driver tasks start and end 1 time unit after a falling edge.
  task automatic load_mem();
    for (int i = 0; i < 17; i++) begin
      @(negedge clock); #1;
      pl_en = 1'b1;
      if (i == 16) begin
        pl_addr = COUNT_ADDR;
        pl_data = 16'(ref_count);
      end else begin
        pl_addr = SINK_BASE + 11'(2 * i);
        pl_data = ref_entries[i];
      end
    end
    @(negedge clock); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_req(input logic [15:0] id, input logic ins, input bit keep);
    int k;
    k = 0;
    bus.req_id     = id;
    bus.req_insert = ins;
    bus.req_valid  = 1'b1;
    while (!bus.req_ready && k < 100) begin
      @(negedge clock); #1;
      k++;
    end
    if (!bus.req_ready) begin
      check("req_accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    exp_q.push_back(model_req(id, ins));
    @(negedge clock); #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clock); #1;
      k++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic mem_compare();
    for (int i = 0; i < 16; i++)
      check("mem_entry", word(SINK_BASE + 11'(2 * i)), ref_entries[i]);
    check("mem_count", word(COUNT_ADDR), ref_count);
  endtask

  task automatic preload5();
    ref_entries[0] = 16'd2;
    ref_entries[1] = 16'd5;
    ref_entries[2] = 16'd10;
    ref_entries[3] = 16'd171;
    ref_entries[4] = 16'd205;
    for (int i = 5; i < 16; i++) ref_entries[i] = 16'($urandom_range(1000, 60000));
    ref_count = 5;
    load_mem();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_resp_valid"}, bus.resp_valid, 0);
    check({tag, "_resp_found"}, bus.resp_found, 0);
    check({tag, "_resp_inserted"}, bus.resp_inserted, 0);
    check({tag, "_resp_full"}, bus.resp_full, 0);
    check({tag, "_resp_index"}, bus.resp_index, 0);
    check({tag, "_mem_wr_en"}, bus.mem_wr_en, 0);
    check({tag, "_mem_address"}, bus.mem_address, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_req_ready"}, bus.req_ready, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    bus.req_valid  = 1'b0;
    bus.req_id     = '0;
    bus.req_insert = 1'b0;
    #1 nrst = 1'b0;
    #2;
    check_idle_outputs("reset");
    @(negedge clock); #1;
    nrst = 1'b1;
    @(negedge clock); #1;
    check("req_ready_after_reset", bus.req_ready, 1);

    // Hit at index 2.
    preload5();
    do_req(16'd10, 1'b0, 1'b0);
    drain();
    check("hit_found", last_found, 1);
    check("hit_index", last_index, 2);
    check("hit_latency", last_lat, 5);

    // Append 7, then find it.
    do_req(16'd7, 1'b1, 1'b0);
    drain();
    check("ins_inserted", last_inserted, 1);
    check("ins_index", last_index, 5);
    check("ins_latency", last_lat, 10);
    check("ins_word_0x012", word(11'h012), 7);
    check("ins_count_word", word(COUNT_ADDR), 6);
    do_req(16'd7, 1'b0, 1'b0);
    drain();
    check("refind_found", last_found, 1);
    check("refind_index", last_index, 5);

    // Miss without insert.
    preload5();
    do_req(16'd7, 1'b0, 1'b0);
    drain();
    check("miss_latency", last_lat, 8);
    check("miss_flags", {last_found, last_inserted, last_full}, 0);
    mem_compare();

    // Full list, then oversized stored count.
    for (int i = 0; i < 16; i++) ref_entries[i] = 16'(i + 1);
    ref_count = 16;
    load_mem();
    do_req(16'd99, 1'b1, 1'b0);
    drain();
    check("full_flag", last_full, 1);
    check("full_latency", last_lat, 19);
    ref_count = 40;
    load_mem();
    do_req(16'd99, 1'b1, 1'b0);
    drain();
    check("clamp_full_flag", last_full, 1);
    check("clamp_latency", last_lat, 19);
    mem_compare();

    // Empty list, ID 0 appended.
    for (int i = 0; i < 16; i++) ref_entries[i] = 16'($urandom_range(1, 60000));
    ref_count = 0;
    load_mem();
    do_req(16'd0, 1'b1, 1'b0);
    drain();
    check("empty_inserted", last_inserted, 1);
    check("empty_index", last_index, 0);
    check("empty_latency", last_lat, 5);
    check("empty_entry0", word(SINK_BASE), 0);
    check("empty_count", word(COUNT_ADDR), 1);

    // Reset during the count write: entry lands, count does not.
    preload5();
    do_req(16'd7, 1'b1, 1'b0);
    k = 0;
    while (!(bus.mem_wr_en && bus.mem_address == COUNT_ADDR) && k < 50) begin
      @(negedge clock);
      k++;
    end
    check("wrcnt_reached", (bus.mem_wr_en && bus.mem_address == COUNT_ADDR), 1);
    #2 nrst = 1'b0;
    #1;
    check_idle_outputs("midreset");
    exp_q.delete();
    ref_count = 5;
    @(negedge clock); #1;
    nrst = 1'b1;
    @(negedge clock); #1;
    check("req_ready_after_midreset", bus.req_ready, 1);
    mem_compare();
    do_req(16'd7, 1'b0, 1'b0);
    drain();
    check("stale_not_read_found", last_found, 0);
    check("stale_not_read_latency", last_lat, 8);

    // Randomised back-to-back traffic with req_valid held high.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) ref_entries[i] = 16'($urandom_range(0, 7));
      ref_count = (r == 3) ? 20 : int'($urandom_range(0, 16));
      load_mem();
      for (int j = 0; j < 12; j++)
        do_req(16'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), j != 11);
      drain();
      mem_compare();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
